// File: rtl/rom_read_arbiter.sv
// Two-port arbiter (CPU fetch + debug readback) in front of a combinational-read ROM.
// Optional `ROM_ARB_FETCH_PRIORITY_EN selects fixed fetch priority instead of round-robin.
module rom_read_arbiter #(
    parameter int              ADDR_W         = 32,
    parameter int              DATA_W         = 32,
    parameter int              ROM_DEPTH_LOG2 = 8,
    parameter logic [DATA_W-1:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t            r_state, w_next;
    logic              r_owner, r_last, r_err;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_f_rdata, r_d_rdata;
    logic              r_f_rvalid, r_d_rvalid, r_f_err, r_d_err;

    logic              w_pick_d;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr;

    always_comb begin
        w_next = r_state;
        f_gnt  = 1'b0;
        d_gnt  = 1'b0;
`ifdef ROM_ARB_FETCH_PRIORITY_EN
        w_pick_d = d_req & ~f_req;
`else
        // On a tie, debug wins only if fetch was served last.
        w_pick_d = d_req & (~f_req | (r_last == OWN_F));
`endif
        w_addr = w_pick_d ? d_addr : f_addr;
        w_err  = (w_addr[1:0] != 2'b00) |
                 (w_addr[ADDR_W-1:ROM_DEPTH_LOG2+2] != '0);
        case (r_state)
            IDLE: begin
                if (f_req | d_req) begin
                    f_gnt  = ~w_pick_d;
                    d_gnt  = w_pick_d;
                    w_next = READ;
                end
            end
            READ:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_owner    <= OWN_F;
            r_last     <= OWN_D;
            r_err      <= 1'b0;
            r_rom_addr <= '0;
            r_f_rdata  <= '0;
            r_d_rdata  <= '0;
            r_f_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_f_err    <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_f_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_f_err    <= 1'b0;
            r_d_err    <= 1'b0;
            if (r_state == IDLE && (f_req | d_req)) begin
                r_owner <= w_pick_d;
                r_last  <= w_pick_d;
                r_err   <= w_err;
                // Bad addresses never reach the ROM bus.
                if (!w_err)
                    r_rom_addr <= w_addr;
            end
            if (r_state == READ) begin
                if (r_owner == OWN_D) begin
                    r_d_rdata  <= r_err ? NOP_WORD : rom_data;
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= r_err;
                end else begin
                    r_f_rdata  <= r_err ? NOP_WORD : rom_data;
                    r_f_rvalid <= 1'b1;
                    r_f_err    <= r_err;
                end
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign f_rdata  = r_f_rdata;
    assign d_rdata  = r_d_rdata;
    assign f_rvalid = r_f_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign f_err    = r_f_err;
    assign d_err    = r_d_err;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed cases plus randomized traffic
// against a transaction-level reference model (honours ROM_ARB_FETCH_PRIORITY_EN).
module tb_rom_read_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_req, d_req;
    logic [31:0] f_addr, d_addr;
    logic        f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err;
    logic [31:0] f_rdata, d_rdata, rom_addr, rom_data;

    logic [31:0] rom [256];

    int n_cmp = 0;
    int n_bad = 0;

    // reference-model state
    bit          m_last_d;
    logic [31:0] m_f_rdata, m_d_rdata, m_rom_addr;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[9:2]];

    rom_read_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1: return $urandom_range(0, 255) * 4;
            2:    return $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
            3:    return 32'd1024 + $urandom_range(0, 4096) * 4;
            4:    return 32'h0000_03FC;
            default: return 32'h0000_0400;
        endcase
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_last_d   = 1'b1;
        m_f_rdata  = '0;
        m_d_rdata  = '0;
        m_rom_addr = '0;
    endtask

    // Entered just after a posedge with the DUT in IDLE and requests driven.
    // Returns just after the posedge that brings the DUT back to IDLE.
    task automatic run_txn(input string tag);
        bit          win_d, bad;
        logic [31:0] a, data;
`ifdef ROM_ARB_FETCH_PRIORITY_EN
        win_d = d_req && !f_req;
`else
        win_d = (f_req && d_req) ? !m_last_d : d_req;
`endif
        m_last_d = win_d;
        a    = win_d ? d_addr : f_addr;
        bad  = addr_bad(a);
        data = bad ? NOP : rom[a[9:2]];
        if (!bad) m_rom_addr = a;
        if (win_d) m_d_rdata = data; else m_f_rdata = data;

        @(negedge clk);
        chk({tag, ".f_gnt"}, 32'(f_gnt), 32'(!win_d));
        chk({tag, ".d_gnt"}, 32'(d_gnt), 32'(win_d));
        chk({tag, ".idle_rv"}, {30'd0, f_rvalid, d_rvalid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".read_gnt"}, {30'd0, f_gnt, d_gnt}, 32'd0);
        chk({tag, ".rom_addr"}, rom_addr, m_rom_addr);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".resp_gnt"}, {30'd0, f_gnt, d_gnt}, 32'd0);
        chk({tag, ".f_rvalid"}, 32'(f_rvalid), 32'(!win_d));
        chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(win_d));
        chk({tag, ".f_err"}, 32'(f_err), 32'(!win_d && bad));
        chk({tag, ".d_err"}, 32'(d_err), 32'(win_d && bad));
        chk({tag, ".f_rdata"}, f_rdata, m_f_rdata);
        chk({tag, ".d_rdata"}, d_rdata, m_d_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[1] = 32'h4012_04B3;
        f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst.rv_err", {28'd0, f_rvalid, d_rvalid, f_err, d_err}, 32'd0);
        chk("rst.rom_addr", rom_addr, 32'd0);
        chk("rst.f_rdata", f_rdata, 32'd0);
        chk("rst.d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;

        // both held continuously: F, D, F, D (or all F with fixed priority)
        do_reset();
        f_req = 1'b1; d_req = 1'b1;
        f_addr = 32'h10; d_addr = 32'h20;
        for (int i = 0; i < 4; i++) run_txn($sformatf("tie%0d", i));

        // single fetch at word 1
        do_reset();
        f_req = 1'b1; d_req = 1'b0; f_addr = 32'h4;
        run_txn("fetch1");
        chk("fetch1.data", f_rdata, 32'h4012_04B3);
        f_req = 1'b0;

        // debug error / boundary addresses
        d_req = 1'b1;
        d_addr = 32'h6;   run_txn("dbg_mis");
        chk("dbg_mis.nop", d_rdata, NOP);
        d_addr = 32'h400; run_txn("dbg_oor");
        chk("dbg_oor.nop", d_rdata, NOP);
        d_addr = 32'h3FC; run_txn("dbg_last");
        chk("dbg_last.word", d_rdata, rom[255]);
        d_req = 1'b0;

        // reset during READ cancels the fetch
        f_req = 1'b1; f_addr = 32'h8;
        @(negedge clk);
        chk("rstrd.f_gnt", 32'(f_gnt), 32'd1);
        @(posedge clk); #1;
        f_req = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_last_d = 1'b1; m_f_rdata = '0; m_d_rdata = '0; m_rom_addr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstrd.f_rvalid", 32'(f_rvalid), 32'd0);
            chk("rstrd.f_rdata", f_rdata, 32'd0);
            @(posedge clk); #1;
        end

        // fetch pulse while debug owns the ROM is ignored
        d_req = 1'b1; d_addr = 32'h40;
        @(negedge clk);
        chk("pulse.d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; f_req = 1'b1; f_addr = 32'h44;
        @(negedge clk);
        chk("pulse.f_gnt_read", 32'(f_gnt), 32'd0);
        @(posedge clk); #1;
        f_req = 1'b0;
        @(negedge clk);
        chk("pulse.d_rvalid", 32'(d_rvalid), 32'd1);
        chk("pulse.d_rdata", d_rdata, rom[16]);
        chk("pulse.f_rvalid", 32'(f_rvalid), 32'd0);
        m_d_rdata = rom[16]; m_rom_addr = 32'h40; m_last_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("pulse.no_f", {30'd0, f_gnt, f_rvalid}, 32'd0);
        end
        @(posedge clk); #1;

        // randomized traffic; a loser keeps its request, a winner re-rolls
        f_req = 1'b1; f_addr = rand_addr();
        d_req = 1'($urandom_range(0, 1)); d_addr = rand_addr();
        for (int i = 0; i < 40; i++) begin
            run_txn($sformatf("rnd%0d", i));
            if (m_last_d) begin
                d_req = 1'($urandom_range(0, 1)); d_addr = rand_addr();
            end else begin
                f_req = 1'($urandom_range(0, 1)); f_addr = rand_addr();
            end
            if (!f_req && !d_req) f_req = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
